// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding and PC source selects.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSetPc   = 3'd1,
        StCollect = 3'd2,
        StWrite   = 3'd3,
        StReload  = 3'd4,
        StDone    = 3'd5
    } state_e;

    localparam logic [1:0] PcSelBr  = 2'b00;
    localparam logic [1:0] PcSelInW = 2'b10;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian 4-byte packer: each shift moves the word left one byte and appends byte_in_i.
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_in_i,
    output logic [31:0] word_o,
    output logic        full_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_i) begin
            word_d = {word_q[23:0], byte_in_i};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o = word_q;
    // Three bytes held: the next shift completes the word.
    assign full_o = (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Packs a byte stream into big-endian words and writes them to instruction memory by driving
// the instruction unit's PC load/increment and memory write strobes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CNT_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  word_count_i,
    input  logic [7:0]        byte_in_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              pc_ld_o,
    output logic [1:0]        pc_sel_o,
    output logic [31:0]       pc_inw_o,
    output logic              pc_inc_o,
    output logic              im_cs_o,
    output logic              im_wr_o,
    output logic [31:0]       d_in_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned MaxWords = 2 ** (ADDR_W - 2);

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  remaining_q;
    logic              byte_ready_q;
    logic              pc_ld_q;
    logic [1:0]        pc_sel_q;
    logic              pc_inc_q;
    logic              im_wr_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic [31:0]       word;
    logic              pack_full;
    logic              pack_clr;
    logic              pack_shift;
    logic [ADDR_W:0]   end_addr;
    logic              args_ok;

    // The count range check keeps the ADDR_W+1 bit end-address sum from wrapping.
    always_comb begin
        end_addr = {1'b0, base_addr_i} + ((ADDR_W + 1)'(word_count_i) << 2);
        args_ok  = (base_addr_i[1:0] == 2'b00)
                 && (word_count_i != '0)
                 && (word_count_i <= CNT_W'(MaxWords))
                 && (end_addr <= (ADDR_W + 1)'(2 ** ADDR_W));
    end

    assign pack_clr   = abort_i || (state_q == StIdle);
    assign pack_shift = byte_ready_q && byte_valid_i && !abort_i;

    imem_loader_byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (pack_clr),
        .shift_i   (pack_shift),
        .byte_in_i (byte_in_i),
        .word_o    (word),
        .full_o    (pack_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            base_q       <= '0;
            remaining_q  <= '0;
            byte_ready_q <= 1'b0;
            pc_ld_q      <= 1'b0;
            pc_sel_q     <= PcSelBr;
            pc_inc_q     <= 1'b0;
            im_wr_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            pc_ld_q  <= 1'b0;
            pc_sel_q <= PcSelBr;
            pc_inc_q <= 1'b0;
            im_wr_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            if (abort_i) begin
                state_q      <= StIdle;
                byte_ready_q <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            if (args_ok) begin
                                state_q     <= StSetPc;
                                base_q      <= base_addr_i;
                                remaining_q <= word_count_i;
                                pc_ld_q     <= 1'b1;
                                pc_sel_q    <= PcSelInW;
                                busy_q      <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    StSetPc: begin
                        state_q      <= StCollect;
                        byte_ready_q <= 1'b1;
                    end
                    StCollect: begin
                        if (byte_valid_i && pack_full) begin
                            state_q      <= StWrite;
                            byte_ready_q <= 1'b0;
                            im_wr_q      <= 1'b1;
                            pc_inc_q     <= 1'b1;
                        end
                    end
                    StWrite: begin
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            state_q  <= StReload;
                            pc_ld_q  <= 1'b1;
                            pc_sel_q <= PcSelInW;
                        end else begin
                            state_q      <= StCollect;
                            byte_ready_q <= 1'b1;
                        end
                    end
                    StReload: begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q      <= StIdle;
                        byte_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign pc_ld_o      = pc_ld_q;
    assign pc_sel_o     = pc_sel_q;
    assign pc_inw_o     = pc_ld_q ? {{(32 - ADDR_W){1'b0}}, base_q} : 32'h0;
    assign pc_inc_o     = pc_inc_q;
    assign im_cs_o      = im_wr_q;
    assign im_wr_o      = im_wr_q;
    assign d_in_o       = im_wr_q ? word : 32'h0;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench: a behavioural instruction unit (PC + byte memory) sits on the loader outputs.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] base_addr = '0;
    logic [10:0] word_count = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready, pc_ld, pc_inc, im_cs, im_wr, busy, done, err;
    logic [1:0]  pc_sel;
    logic [31:0] pc_inw, d_in;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .abort_i      (abort),
        .base_addr_i  (base_addr),
        .word_count_i (word_count),
        .byte_in_i    (byte_in),
        .byte_valid_i (byte_valid),
        .byte_ready_o (byte_ready),
        .pc_ld_o      (pc_ld),
        .pc_sel_o     (pc_sel),
        .pc_inw_o     (pc_inw),
        .pc_inc_o     (pc_inc),
        .im_cs_o      (im_cs),
        .im_wr_o      (im_wr),
        .d_in_o       (d_in),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic [7:0]  mem [0:4095];
    logic [31:0] pc_model = '0;
    logic [7:0]  tx_q [$];
    wr_t         exp_q [$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [31:0] rd_word(input int addr);
        return {mem[addr], mem[addr + 1], mem[addr + 2], mem[addr + 3]};
    endfunction

    // Behavioural instruction unit: write at current PC, then load or advance PC.
    always @(posedge clk) begin
        cyc++;
        if (im_cs && im_wr) begin
            mem[pc_model[11:0]]     <= d_in[31:24];
            mem[pc_model[11:0] + 1] <= d_in[23:16];
            mem[pc_model[11:0] + 2] <= d_in[15:8];
            mem[pc_model[11:0] + 3] <= d_in[7:0];
        end
        if (pc_ld && pc_sel == 2'b10) pc_model <= pc_inw;
        else if (pc_inc) pc_model <= pc_model + 32'd4;
    end

    // Monitor: every memory write must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) err_cnt++;
        if (pc_ld) check("pc_sel_on_ld", {30'd0, pc_sel}, 32'd2);
        if (im_wr) begin
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", pc_model, e.addr);
                check("write_data", d_in, e.data);
                check("write_strobes", {30'd0, im_cs, pc_inc}, 32'd3);
            end
        end
    end

    task automatic push_word(input logic [31:0] addr, input logic [31:0] w, input bit expect_wr);
        tx_q.push_back(w[31:24]);
        tx_q.push_back(w[23:16]);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
        if (expect_wr) exp_q.push_back({addr, w});
    endtask

    task automatic issue_start(input logic [11:0] base, input logic [10:0] cnt);
        @(negedge clk);
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        start_cyc  = cyc;
    endtask

    task automatic send_bytes(input int n, input bit gap);
        int  sent = 0;
        int  guard = 0;
        bit  phase = 1'b0;
        while (sent < n && tx_q.size() != 0 && guard < 20 * n + 100) begin
            @(negedge clk);
            guard++;
            byte_valid = gap ? phase : 1'b1;
            phase      = ~phase;
            byte_in    = tx_q[0];
            if (byte_valid && byte_ready) begin
                void'(tx_q.pop_front());
                sent++;
            end
        end
        check("bytes_sent", sent, n);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int max);
        int g = 0;
        while (done_cnt == prev && g < max) begin
            @(negedge clk);
            #1;
            g++;
        end
        check("done_seen", 32'(done_cnt - prev), 32'd1);
    endtask

    initial begin
        int prev;
        int errs;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        // Reset state
        #12;
        check("reset_outs", {byte_ready, pc_ld, pc_sel, pc_inc, im_cs, im_wr, busy, done, err},
              32'd0);
        check("reset_buses", pc_inw | d_in, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outs", {byte_ready, busy, done, err}, 32'd0);

        // 1: two words back-to-back at 0x000
        prev = done_cnt;
        push_word(32'h000, 32'h8C010004, 1'b1);
        push_word(32'h004, 32'h20420001, 1'b1);
        issue_start(12'h000, 11'd2);
        check("t1_busy", {31'd0, busy}, 32'd1);
        send_bytes(8, 1'b0);
        wait_done(prev, 50);
        check("t1_latency", 32'(done_cyc - start_cyc), 32'd12);
        @(negedge clk);
        check("t1_busy_after", {31'd0, busy}, 32'd0);
        check("t1_pc", pc_model, 32'h000);
        check("t1_mem0", rd_word(0), 32'h8C010004);
        check("t1_mem4", rd_word(4), 32'h20420001);

        // 2: one word at 0x100 with gapped valid
        prev = done_cnt;
        push_word(32'h100, 32'h11223344, 1'b1);
        issue_start(12'h100, 11'd1);
        send_bytes(4, 1'b1);
        wait_done(prev, 50);
        @(negedge clk);
        check("t2_mem", rd_word(32'h100), 32'h11223344);
        check("t2_pc", pc_model, 32'h100);

        // 3: rejected arguments
        errs = err_cnt;
        issue_start(12'h102, 11'd1);
        check("t3_err_misaligned", {30'd0, err, busy}, 32'd2);
        @(negedge clk);
        check("t3_err_pulse", {31'd0, err}, 32'd0);
        issue_start(12'hFFC, 11'd2);
        check("t3_err_overflow", {30'd0, err, busy}, 32'd2);
        issue_start(12'h010, 11'd0);
        check("t3_err_zero", {30'd0, err, busy}, 32'd2);
        @(negedge clk);
        check("t3_err_count", 32'(err_cnt - errs), 32'd3);
        // Last word of memory is a legal single-word load
        prev = done_cnt;
        push_word(32'hFFC, 32'hCAFEF00D, 1'b1);
        issue_start(12'hFFC, 11'd1);
        check("t3_edge_noerr", {30'd0, err, busy}, 32'd1);
        send_bytes(4, 1'b0);
        wait_done(prev, 50);
        @(negedge clk);
        check("t3_edge_mem", rd_word(32'hFFC), 32'hCAFEF00D);

        // 4: abort after 2 bytes of word 2
        prev = done_cnt;
        push_word(32'h200, 32'hA1B2C3D4, 1'b1);
        push_word(32'h204, 32'h55667788, 1'b0);
        issue_start(12'h200, 11'd3);
        send_bytes(6, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_busy", {30'd0, busy, byte_ready}, 32'd0);
        repeat (10) @(negedge clk);
        check("t4_no_done", 32'(done_cnt - prev), 32'd0);
        check("t4_pc", pc_model, 32'h204);
        check("t4_mem_w1", rd_word(32'h200), 32'hA1B2C3D4);
        check("t4_mem_w2", rd_word(32'h204), 32'h0);
        tx_q.delete();
        prev = done_cnt;
        push_word(32'h300, 32'h0BADBEEF, 1'b1);
        issue_start(12'h300, 11'd1);
        send_bytes(4, 1'b0);
        wait_done(prev, 50);
        @(negedge clk);
        check("t4_restart_mem", rd_word(32'h300), 32'h0BADBEEF);

        // 5: asynchronous reset mid-COLLECT
        prev = done_cnt;
        push_word(32'h400, 32'h01020304, 1'b1);
        push_word(32'h404, 32'h05060708, 1'b0);
        issue_start(12'h400, 11'd2);
        send_bytes(5, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_outs",
              {byte_ready, pc_ld, pc_sel, pc_inc, im_cs, im_wr, busy, done, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tx_q.delete();
        repeat (3) @(negedge clk);
        check("t5_idle", {31'd0, busy}, 32'd0);
        check("t5_no_done", 32'(done_cnt - prev), 32'd0);
        check("t5_mem_kept", rd_word(32'h400), 32'h01020304);
        check("t5_mem_old", rd_word(0), 32'h8C010004);

        // 6: full-memory load with a start pulse while busy
        prev = done_cnt;
        errs = err_cnt;
        for (int i = 0; i < 1024; i++) push_word(32'(4 * i), 32'h10000000 + 32'(i) * 32'h00010003,
                                                 1'b1);
        issue_start(12'h000, 11'd1024);
        fork
            send_bytes(4096, 1'b0);
            begin
                repeat (100) @(negedge clk);
                base_addr  = 12'h102;
                word_count = 11'd1;
                start      = 1'b1;
                @(negedge clk);
                start      = 1'b0;
            end
        join
        wait_done(prev, 50);
        check("t6_latency", 32'(done_cyc - start_cyc), 32'd5122);
        @(negedge clk);
        check("t6_no_err", 32'(err_cnt - errs), 32'd0);
        check("t6_pc", pc_model, 32'h000);
        check("t6_mem_first", rd_word(0), 32'h10000000);
        check("t6_mem_last", rd_word(4092), 32'h10000000 + 32'd1023 * 32'h00010003);
        check("writes_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
